// File: rtl/key_event_decoder.sv
// Turns debounced key strobes into short-press, long-press and double-click
// pulses, and drives a registered LED that reacts to each gesture.
module key_event_decoder #(
  parameter int unsigned LONG_CYC = 50_000_000,
  parameter int unsigned GAP_CYC  = 15_000_000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_flag,
  input  logic key_value,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic led
);

  typedef enum logic [1:0] {IDLE, PRESS1, WAIT2, HOLD} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             short_nxt, long_nxt, double_nxt, led_nxt;
  logic             key_press, key_release;

  assign key_press   = key_flag & ~key_value;
  assign key_release = key_flag &  key_value;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      led          <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= double_nxt;
      led          <= led_nxt;
    end
  end

  // Key events are tested before the timeout so a coincident event wins.
  always_comb begin
    state_nxt  = state;
    short_nxt  = 1'b0;
    long_nxt   = 1'b0;
    double_nxt = 1'b0;
    led_nxt    = led;
    case (state)
      IDLE: begin
        if (key_press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (key_release) begin
          state_nxt = WAIT2;
        end else if (cnt == LONG_LAST) begin
          long_nxt  = 1'b1;
          led_nxt   = 1'b0;
          state_nxt = HOLD;
        end
      end
      WAIT2: begin
        if (key_press) begin
          double_nxt = 1'b1;
          led_nxt    = 1'b1;
          state_nxt  = HOLD;
        end else if (cnt == GAP_LAST) begin
          short_nxt = 1'b1;
          led_nxt   = ~led;
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (key_release) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = '0;
    if (state_nxt == state && (state == PRESS1 || state == WAIT2)) begin
      if (cnt != '1) cnt_nxt = cnt + 1'b1;
      else           cnt_nxt = cnt;
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short timeouts; pulse cycles are
// recorded by a monitor and compared against hand-derived cycle numbers.
module tb_key_event_decoder;

  localparam int unsigned LONG_CYC = 100;
  localparam int unsigned GAP_CYC  = 40;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic key_flag;
  logic key_value;
  logic short_press, long_press, double_click, led;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sp_cnt = 0, lp_cnt = 0, dc_cnt = 0, multi_cnt = 0;
  int sp_cyc = -1, lp_cyc = -1, dc_cyc = -1;

  key_event_decoder #(
    .LONG_CYC(LONG_CYC),
    .GAP_CYC (GAP_CYC),
    .CNT_W   (8)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .key_flag    (key_flag),
    .key_value   (key_value),
    .short_press (short_press),
    .long_press  (long_press),
    .double_click(double_click),
    .led         (led)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulses are observed mid-cycle; cyc then names the edge that produced them.
  always @(negedge sys_clk) begin
    if (short_press)  begin sp_cnt++; sp_cyc = cyc; end
    if (long_press)   begin lp_cnt++; lp_cyc = cyc; end
    if (double_click) begin dc_cnt++; dc_cyc = cyc; end
    if (int'(short_press) + int'(long_press) + int'(double_click) > 1) multi_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic strobe(input logic val);
    key_flag  = 1'b1;
    key_value = val;
    tick();
    key_flag  = 1'b0;
  endtask

  int p, r;

  initial begin
    sys_rst   = 1'b1;
    key_flag  = 1'b0;
    key_value = 1'b1;
    repeat (3) tick();
    check("rst_short", int'(short_press), 0);
    check("rst_long",  int'(long_press), 0);
    check("rst_dbl",   int'(double_click), 0);
    check("rst_led",   int'(led), 0);
    sys_rst = 1'b0;
    tick();

    // Release in IDLE is ignored
    strobe(1'b1);
    repeat (60) tick();
    check("idle_rel_pulses", sp_cnt + lp_cnt + dc_cnt, 0);
    check("idle_rel_led", int'(led), 0);

    // Short press: led 0 -> 1
    p = cyc; strobe(1'b0);
    wait_to(p + 20); r = cyc; strobe(1'b1);
    wait_to(r + 60);
    check("short1_cnt", sp_cnt, 1);
    check("short1_cyc", sp_cyc, r + 41);
    check("short1_led", int'(led), 1);
    check("short1_other", lp_cnt + dc_cnt, 0);

    // Second short press: led 1 -> 0
    p = cyc; strobe(1'b0);
    wait_to(p + 20); r = cyc; strobe(1'b1);
    wait_to(r + 60);
    check("short2_cnt", sp_cnt, 2);
    check("short2_cyc", sp_cyc, r + 41);
    check("short2_led", int'(led), 0);

    // Double click: led forced 1, no short press, release silent
    p = cyc; strobe(1'b0);
    wait_to(p + 10); strobe(1'b1);
    wait_to(p + 30); strobe(1'b0);
    wait_to(p + 60); strobe(1'b1);
    wait_to(p + 130);
    check("dbl_cnt", dc_cnt, 1);
    check("dbl_cyc", dc_cyc, p + 31);
    check("dbl_led", int'(led), 1);
    check("dbl_no_short", sp_cnt, 2);

    // Long press held 150 cycles: led forced 0, release silent
    p = cyc; strobe(1'b0);
    wait_to(p + 150);
    check("long_cnt", lp_cnt, 1);
    check("long_cyc", lp_cyc, p + 101);
    check("long_led", int'(led), 0);
    strobe(1'b1);
    wait_to(p + 220);
    check("long_rel_pulses", sp_cnt + lp_cnt + dc_cnt, 4);

    // Boundary: release on the long-timeout cycle, second press on the gap-timeout cycle
    p = cyc; strobe(1'b0);
    wait_to(p + 100); r = cyc; strobe(1'b1);
    wait_to(r + 40); strobe(1'b0);
    wait_to(r + 60); strobe(1'b1);
    wait_to(r + 130);
    check("bnd_no_long", lp_cnt, 1);
    check("bnd_dbl_cnt", dc_cnt, 2);
    check("bnd_dbl_cyc", dc_cyc, r + 41);
    check("bnd_no_short", sp_cnt, 2);
    check("bnd_led", int'(led), 1);

    // Mid-gesture reset aborts the long press
    p = cyc; strobe(1'b0);
    wait_to(p + 50);
    sys_rst = 1'b1;
    tick(); tick();
    check("mid_rst_led", int'(led), 0);
    sys_rst = 1'b0;
    wait_to(p + 200);
    check("mid_rst_no_long", lp_cnt, 1);

    // Fresh short press after reset
    strobe(1'b1);
    tick();
    p = cyc; strobe(1'b0);
    wait_to(p + 20); r = cyc; strobe(1'b1);
    wait_to(r + 60);
    check("post_rst_short_cnt", sp_cnt, 3);
    check("post_rst_short_cyc", sp_cyc, r + 41);
    check("post_rst_led", int'(led), 1);

    check("one_hot_pulses", multi_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
